// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - SPI serial shift data path between SCLK strobes and parallel words
module spi_shift_engine #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET_n,
  input  logic                  ss_i,
  input  logic                  send_data_i,
  input  logic                  lsbfe_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  mosi_send_sclk_i,
  input  logic                  mosi_send_sclk0_i,
  input  logic                  miso_receive_sclk_i,
  input  logic                  miso_receive_sclk0_i,
  input  logic [DATA_WIDTH-1:0] data_mosi_i,
  input  logic                  miso_i,
  output logic                  mosi_o,
  output logic [DATA_WIDTH-1:0] data_miso_o,
  output logic                  rx_done_o,
  output logic                  busy_o
);

  // Counters must be able to hold DATA_WIDTH itself, hence the extra bit.
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic rst_meta;
  logic rst_sync_n;

  logic send_stb;
  logic recv_stb;

  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [CW-1:0]         tx_cnt;
  logic [CW-1:0]         rx_cnt;
  logic [CW-1:0]         tx_idx;
  logic [CW-1:0]         rx_idx;
  logic                  tx_bit;
  logic                  tx_more;
  logic                  rx_more;
  logic                  rx_last;

  logic do_load;
  logic do_send;
  logic do_recv;
  logic do_finish;
  logic do_abort;

  // Reset asserts immediately but releases only after two clean PCLK edges.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  // Modes where polarity equals phase use the plain strobes, the others the *_sclk0 pair.
  assign send_stb = (cpol_i == cpha_i) ? mosi_send_sclk_i    : mosi_send_sclk0_i;
  assign recv_stb = (cpol_i == cpha_i) ? miso_receive_sclk_i : miso_receive_sclk0_i;

  assign tx_more = (tx_cnt < CNT_FULL);
  assign rx_more = (rx_cnt < CNT_FULL);
  assign rx_last = (rx_cnt == CNT_LAST);

  // Bit position addressed by each counter for the selected bit order.
  assign tx_idx = lsbfe_i ? tx_cnt : (CNT_LAST - tx_cnt);
  assign rx_idx = lsbfe_i ? rx_cnt : (CNT_LAST - rx_cnt);

  // Select the outgoing bit and build the receive word with the incoming bit merged in.
  always_comb begin
    tx_bit  = 1'b0;
    rx_next = rx_sr;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (tx_idx == CW'(i)) tx_bit = tx_sr[i];
      if (rx_idx == CW'(i)) rx_next[i] = miso_i;
    end
  end

  // State register.
  always_ff @(posedge PCLK or negedge rst_sync_n) begin
    if (!rst_sync_n) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Next-state logic; slave select going high wins over everything else in a frame.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (send_data_i && !ss_i) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        state_nxt = ss_i ? ST_IDLE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (ss_i)                                   state_nxt = ST_IDLE;
        else if (recv_stb && rx_more && rx_last)    state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Per-state datapath controls.
  always_comb begin
    do_load   = 1'b0;
    do_send   = 1'b0;
    do_recv   = 1'b0;
    do_finish = 1'b0;
    do_abort  = 1'b0;
    case (state)
      ST_LOAD: begin
        if (ss_i) do_abort = 1'b1;
        else      do_load  = 1'b1;
      end
      ST_SHIFT: begin
        if (ss_i) begin
          do_abort = 1'b1;
        end else begin
          do_send   = send_stb && tx_more;
          do_recv   = recv_stb && rx_more;
          do_finish = recv_stb && rx_more && rx_last;
        end
      end
      default: ;
    endcase
  end

  // Shift registers, bit counters and the serial output.
  always_ff @(posedge PCLK or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      tx_sr  <= '0;
      rx_sr  <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
      mosi_o <= 1'b0;
    end else if (do_load) begin
      tx_sr  <= data_mosi_i;
      rx_sr  <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else if (do_abort) begin
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else begin
      if (do_send) begin
        mosi_o <= tx_bit;
        tx_cnt <= tx_cnt + CNT_ONE;
      end
      if (do_recv) begin
        rx_sr  <= rx_next;
        rx_cnt <= rx_cnt + CNT_ONE;
      end
    end
  end

  // Completed-word hand-off and busy flag, both aligned with the state register.
  always_ff @(posedge PCLK or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      data_miso_o <= '0;
      rx_done_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      rx_done_o <= do_finish;
      busy_o    <= (state_nxt != ST_IDLE);
      if (do_finish) data_miso_o <= rx_next;
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb/tb_spi_shift_engine.sv - directed and randomized frame checks for spi_shift_engine
module tb_spi_shift_engine;

  logic       PCLK = 1'b0;
  logic       PRESET_n;
  logic       ss;
  logic       send_data;
  logic       lsbfe;
  logic       cpol;
  logic       cpha;
  logic       msend;
  logic       msend0;
  logic       mrecv;
  logic       mrecv0;
  logic [7:0] data_mosi;
  logic       miso;
  logic       mosi;
  logic [7:0] data_miso;
  logic       rx_done;
  logic       busy;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] prev_word;

  spi_shift_engine #(.DATA_WIDTH(8)) dut (
    .PCLK                 (PCLK),
    .PRESET_n             (PRESET_n),
    .ss_i                 (ss),
    .send_data_i          (send_data),
    .lsbfe_i              (lsbfe),
    .cpol_i               (cpol),
    .cpha_i               (cpha),
    .mosi_send_sclk_i     (msend),
    .mosi_send_sclk0_i    (msend0),
    .miso_receive_sclk_i  (mrecv),
    .miso_receive_sclk0_i (mrecv0),
    .data_mosi_i          (data_mosi),
    .miso_i               (miso),
    .mosi_o               (mosi),
    .data_miso_o          (data_miso),
    .rx_done_o            (rx_done),
    .busy_o               (busy)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input bit s, input bit r, input bit alt);
    if (alt) begin
      msend0 = s;
      mrecv0 = r;
    end else begin
      msend = s;
      mrecv = r;
    end
  endtask

  task automatic clr();
    msend  = 1'b0;
    msend0 = 1'b0;
    mrecv  = 1'b0;
    mrecv0 = 1'b0;
  endtask

  // Wire-order model: the i-th bit on the line is word[i] (LSB first) or word[7-i].
  function automatic logic line_bit(input logic [7:0] w, input bit lsb, input int i);
    logic [7:0] t;
    t = w >> (lsb ? i : 7 - i);
    return t[0];
  endfunction

  task automatic run_frame(input logic [7:0] tx, input logic [7:0] rxw, input bit lsb,
                           input bit loop, input bit same, input int abort_at,
                           input bit repulse, input int extra, input bit wrong);
    bit         alt;
    logic       exp_bit;
    logic       m0;
    logic [7:0] exp_word;
    alt      = (cpol != cpha);
    exp_word = loop ? tx : rxw;
    lsbfe     = lsb;
    data_mosi = tx;
    ss        = 1'b0;
    send_data = 1'b1;
    tick();
    chk1("load_busy", busy, 1'b1);
    chk1("done_pulse_width", rx_done, 1'b0);
    send_data = 1'b0;
    tick();
    data_mosi = 8'($urandom);
    m0 = mosi;
    if (wrong) begin
      for (int k = 0; k < 8; k++) begin
        strobe(1'b1, 1'b1, !alt);
        tick();
        clr();
        tick();
      end
      chk1("wrong_stb_busy", busy, 1'b1);
      chk1("wrong_stb_mosi", mosi, m0);
      chk1("wrong_stb_done", rx_done, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      exp_bit = line_bit(tx, lsb, i);
      if (i == abort_at) begin
        ss = 1'b1;
        tick();
        ss = 1'b0;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_no_done", rx_done, 1'b0);
        chk8("abort_data_kept", data_miso, prev_word);
        return;
      end
      if (repulse && i == 3) begin
        send_data = 1'b1;
        tick();
        send_data = 1'b0;
        chk1("repulse_busy", busy, 1'b1);
      end
      if (same) begin
        miso = line_bit(rxw, lsb, i);
        strobe(1'b1, 1'b1, alt);
        tick();
        clr();
        chk1("mosi_bit", mosi, exp_bit);
      end else begin
        strobe(1'b1, 1'b0, alt);
        tick();
        clr();
        chk1("mosi_bit", mosi, exp_bit);
        if (i == 7) begin
          for (int k = 0; k < extra; k++) begin
            strobe(1'b1, 1'b0, alt);
            tick();
            clr();
            chk1("mosi_hold_extra", mosi, exp_bit);
          end
        end
        miso = loop ? mosi : line_bit(rxw, lsb, i);
        strobe(1'b0, 1'b1, alt);
        tick();
        clr();
      end
      if (i < 7) chk1("no_early_done", rx_done, 1'b0);
    end
    chk1("rx_done", rx_done, 1'b1);
    chk8("data_miso", data_miso, exp_word);
    chk1("busy_end", busy, 1'b0);
    prev_word = exp_word;
  endtask

  initial begin
    bit b_same;
    PRESET_n  = 1'b0;
    ss        = 1'b1;
    send_data = 1'b0;
    lsbfe     = 1'b0;
    cpol      = 1'b0;
    cpha      = 1'b0;
    data_mosi = 8'h00;
    miso      = 1'b0;
    prev_word = 8'h00;
    clr();
    tick();
    tick();
    chk1("rst_mosi", mosi, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", rx_done, 1'b0);
    chk8("rst_data", data_miso, 8'h00);
    PRESET_n = 1'b1;
    tick();
    tick();
    tick();
    send_data = 1'b1;
    tick();
    chk1("ss_high_no_start", busy, 1'b0);
    send_data = 1'b0;
    ss = 1'b0;
    tick();

    // Mode 0, MSB first, loopback.
    run_frame(8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, -1, 1'b0, 0, 1'b0);
    tick();
    chk1("done_one_cycle", rx_done, 1'b0);
    chk8("data_hold_idle", data_miso, 8'hA5);

    // Mode 0, LSB first, MISO tied high.
    run_frame(8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, -1, 1'b0, 0, 1'b0);
    tick();

    // cpol=1 cpha=0: plain strobes must be ignored, sclk0 pair drives the frame.
    cpol = 1'b1;
    cpha = 1'b0;
    run_frame(8'($urandom), 8'h3C, 1'b0, 1'b0, 1'b0, -1, 1'b0, 0, 1'b1);
    tick();

    // Abort after four received bits, then a clean frame.
    cpol = 1'b0;
    cpha = 1'b0;
    run_frame(8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 4, 1'b0, 0, 1'b0);
    tick();
    chk1("abort_stays_idle", busy, 1'b0);
    run_frame(8'h5A, 8'h00, 1'b0, 1'b1, 1'b0, -1, 1'b0, 0, 1'b0);

    // Back-to-back start, mid-frame start re-pulse and two surplus send strobes.
    run_frame(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0, -1, 1'b1, 2, 1'b0);
    tick();

    // Asynchronous reset in the middle of a frame.
    lsbfe     = 1'b0;
    data_mosi = 8'hFF;
    send_data = 1'b1;
    tick();
    send_data = 1'b0;
    tick();
    strobe(1'b1, 1'b0, 1'b0);
    tick();
    clr();
    chk1("pre_reset_mosi", mosi, 1'b1);
    #2;
    PRESET_n = 1'b0;
    #1;
    chk1("async_rst_mosi", mosi, 1'b0);
    chk1("async_rst_busy", busy, 1'b0);
    chk1("async_rst_done", rx_done, 1'b0);
    chk8("async_rst_data", data_miso, 8'h00);
    prev_word = 8'h00;
    tick();
    tick();
    PRESET_n = 1'b1;
    tick();
    tick();
    tick();
    chk1("post_rst_idle", busy, 1'b0);
    run_frame(8'hC3, 8'h00, 1'b0, 1'b1, 1'b0, -1, 1'b0, 0, 1'b0);

    // Randomized frames across modes, bit orders and strobe alignments.
    for (int n = 0; n < 8; n++) begin
      cpol   = 1'($urandom_range(0, 1));
      cpha   = 1'($urandom_range(0, 1));
      b_same = 1'($urandom_range(0, 1));
      run_frame(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                !b_same && 1'($urandom_range(0, 1)), b_same, -1, 1'b0,
                $urandom_range(0, 2), 1'b0);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
